// File: rtl/answer_poll_sched.sv
// answer_poll_sched: shares the answer table's single address port between a
// periodic frame sweep (header plus table bytes streamed to the UART) and
// host single-address reads. A host read may slip in between frame bytes.
module answer_poll_sched #(
  parameter logic [4:0]  FIRST_ADDR = 5'd0,
  parameter logic [4:0]  LAST_ADDR  = 5'd17,
  parameter logic [4:0]  PARK_ADDR  = 5'd1,
  parameter int unsigned READ_LAT   = 2,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_req,
  input  logic       rd_req,
  input  logic [4:0] rd_addr,
  output logic       rd_ack,
  output logic [7:0] rd_data,
  output logic [4:0] addr,
  input  logic [7:0] data,
  output logic [7:0] tx_data,
  output logic       tx_val,
  input  logic       tx_rdy,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] ovr_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    SETUP  = 3'd2,
    WAIT   = 3'd3,
    SEND   = 3'd4,
    HSETUP = 3'd5,
    HWAIT  = 3'd6
  } state_t;

  localparam logic [1:0] WAIT_INIT = 2'(READ_LAT - 1);

  state_t     state;
  state_t     nxt;
  logic [4:0] index;
  logic [1:0] wcnt;
  logic       pending;
  logic       active;
  logic       start_frame;
  logic       last_byte;

  // State register; a low rst abandons whatever was in flight.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  // Next-state selection; the host read wins in IDLE and between frame bytes.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (rd_req)           nxt = HSETUP;
        else if (start_frame) nxt = HDR;
      end
      HDR:    if (tx_rdy) nxt = SETUP;
      SETUP:  nxt = WAIT;
      WAIT:   if (wcnt == 2'd0) nxt = SEND;
      SEND: begin
        if (tx_rdy) begin
          if (last_byte)   nxt = IDLE;
          else if (rd_req) nxt = HSETUP;
          else             nxt = SETUP;
        end
      end
      HSETUP: nxt = HWAIT;
      HWAIT:  if (wcnt == 2'd0) nxt = active ? SETUP : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Status outputs and shared decode terms.
  always_comb begin
    start_frame = 1'b0;
    last_byte   = 1'b0;
    busy        = 1'b0;
    start_frame = (state == IDLE) && !rd_req && (pending || frame_req);
    last_byte   = (index == LAST_ADDR);
    busy        = (state != IDLE) || pending;
  end

  // Datapath: address port, read pipeline wait, UART byte, host result,
  // frame request bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr       <= PARK_ADDR;
      index      <= FIRST_ADDR;
      wcnt       <= 2'd0;
      tx_val     <= 1'b0;
      tx_data    <= 8'd0;
      rd_ack     <= 1'b0;
      rd_data    <= 8'd0;
      frame_done <= 1'b0;
      ovr_cnt    <= 8'd0;
      pending    <= 1'b0;
      active     <= 1'b0;
    end else begin
      rd_ack     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_frame) begin
            index   <= FIRST_ADDR;
            tx_val  <= 1'b1;
            tx_data <= HEADER;
            active  <= 1'b1;
          end
        end
        HDR: begin
          if (tx_rdy) tx_val <= 1'b0;
        end
        SETUP: begin
          addr <= index;
          wcnt <= WAIT_INIT;
        end
        WAIT: begin
          if (wcnt == 2'd0) begin
            tx_data <= data;
            tx_val  <= 1'b1;
          end else begin
            wcnt <= wcnt - 2'd1;
          end
        end
        SEND: begin
          if (tx_rdy) begin
            tx_val <= 1'b0;
            if (last_byte) begin
              frame_done <= 1'b1;
              addr       <= PARK_ADDR;
              active     <= 1'b0;
            end else begin
              index <= index + 5'd1;
            end
          end
        end
        HSETUP: begin
          addr <= rd_addr;
          wcnt <= WAIT_INIT;
        end
        HWAIT: begin
          if (wcnt == 2'd0) begin
            rd_data <= data;
            rd_ack  <= 1'b1;
            if (!active) addr <= PARK_ADDR;
          end else begin
            wcnt <= wcnt - 2'd1;
          end
        end
        default: ;
      endcase

      // A request is dropped when a frame is running or one is already
      // queued; otherwise it either starts a frame now or is queued.
      if (frame_req) begin
        if (active || pending) begin
          if (ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
        end else if (!start_frame) begin
          pending <= 1'b1;
        end
      end
      if (start_frame) pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_answer_poll_sched.sv
// Bench for answer_poll_sched: a registered table model (addr*10), a host
// model that drops rd_req on rd_ack, and a byte scoreboard filled with whole
// expected frames (header then every table address of the sweep).
module tb_answer_poll_sched;

  localparam logic [4:0] FIRST = 5'd0;
  localparam logic [4:0] LAST  = 5'd17;
  localparam logic [4:0] PARK  = 5'd1;
  localparam logic [7:0] HDRB  = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_req;
  logic       rd_req;
  logic [4:0] rd_addr;
  logic       rd_ack;
  logic [7:0] rd_data;
  logic [4:0] addr;
  logic [7:0] data;
  logic [7:0] tx_data;
  logic       tx_val;
  logic       tx_rdy;
  logic       busy;
  logic       frame_done;
  logic [7:0] ovr_cnt;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  int hs_count = 0;
  int ack_count = 0;
  int ack_hs = 0;
  int done_count = 0;
  logic host_pend = 1'b0;
  logic [4:0] host_addr = 5'd0;
  logic inflight = 1'b0;

  always #5 clk = ~clk;

  answer_poll_sched #(
    .FIRST_ADDR(FIRST),
    .LAST_ADDR (LAST),
    .PARK_ADDR (PARK),
    .READ_LAT  (2),
    .HEADER    (HDRB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .frame_req (frame_req),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .addr      (addr),
    .data      (data),
    .tx_data   (tx_data),
    .tx_val    (tx_val),
    .tx_rdy    (tx_rdy),
    .busy      (busy),
    .frame_done(frame_done),
    .ovr_cnt   (ovr_cnt)
  );

  function automatic logic [7:0] tbl(input logic [4:0] a);
    return 8'(int'(a) * 10);
  endfunction

  // Table with one register stage: data valid two cycles after addr changes.
  always @(posedge clk) data <= tbl(addr);

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame();
    exp_q.push_back(HDRB);
    for (int a = int'(FIRST); a <= int'(LAST); a++) exp_q.push_back(tbl(5'(a)));
  endtask

  // One cycle: observe registered pulses, drive inputs, then score any
  // byte that handshakes on the coming edge.
  task automatic apply_stimulus(input logic rdy, input logic fr);
    logic [7:0] e;
    @(negedge clk);
    if (rd_ack === 1'b1) begin
      check_output("rd_ack_expected", host_pend, 1);
      check_output("rd_data", rd_data, tbl(host_addr));
      host_pend = 1'b0;
      ack_count++;
      ack_hs = hs_count;
    end
    if (frame_done === 1'b1) begin
      check_output("frame_done_expected", inflight, 1);
      check_output("frame_len_q_empty", exp_q.size(), 0);
      check_output("addr_parked_at_done", addr, PARK);
      inflight = 1'b0;
      done_count++;
    end
    frame_req = fr;
    rd_req    = host_pend;
    rd_addr   = host_addr;
    tx_rdy    = rdy;
    if (tx_val === 1'b1 && tx_rdy) begin
      check_output("tx_byte_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_output("tx_byte", tx_data, e);
      end
      hs_count++;
    end
  endtask

  task automatic run_to_done(input int max_cycles);
    int start;
    start = done_count;
    for (int i = 0; i < max_cycles && done_count == start; i++) apply_stimulus(1'b1, 1'b0);
    check_output("frame_done_seen", done_count - start, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    frame_req = 1'b0;
    rd_req = 1'b0;
    rd_addr = 5'd0;
    tx_rdy = 1'b0;
    host_pend = 1'b0;
    inflight = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int mark;
    int mark_ack;
    int mark_done;
    int started;
    int exp_ovr;
    logic fr;

    rst = 1'b0;
    frame_req = 1'b0;
    rd_req = 1'b0;
    rd_addr = 5'd0;
    tx_rdy = 1'b0;

    do_reset();
    check_output("rst_tx_val", tx_val, 0);
    check_output("rst_tx_data", tx_data, 0);
    check_output("rst_rd_ack", rd_ack, 0);
    check_output("rst_rd_data", rd_data, 0);
    check_output("rst_frame_done", frame_done, 0);
    check_output("rst_ovr_cnt", ovr_cnt, 0);
    check_output("rst_addr", addr, PARK);
    check_output("rst_busy", busy, 0);

    $display("[TB] basic frame");
    push_frame();
    inflight = 1'b1;
    mark = hs_count;
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b0);
    check_output("t1_busy_hdr", busy, 1);
    check_output("t1_hdr_val", tx_val, 1);
    run_to_done(300);
    check_output("t1_bytes", hs_count - mark, 19);
    apply_stimulus(1'b1, 1'b0);
    check_output("t1_done_one_cycle", frame_done, 0);
    check_output("t1_busy_idle", busy, 0);
    check_output("t1_addr_park", addr, PARK);

    $display("[TB] stall at byte 3");
    push_frame();
    inflight = 1'b1;
    mark = hs_count;
    apply_stimulus(1'b1, 1'b1);
    for (int i = 0; i < 100 && hs_count - mark < 3; i++) apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0);
    for (int i = 0; i < 20 && tx_val !== 1'b1; i++) apply_stimulus(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) apply_stimulus(1'b0, 1'b0);
      check_output("t2_stall_val", tx_val, 1);
      check_output("t2_stall_data", tx_data, 8'd20);
      check_output("t2_stall_addr", addr, 5'd2);
    end
    check_output("t2_no_hs_in_stall", hs_count - mark, 3);
    run_to_done(300);
    check_output("t2_bytes", hs_count - mark, 19);

    $display("[TB] host read mid-frame");
    push_frame();
    inflight = 1'b1;
    mark = hs_count;
    mark_ack = ack_count;
    apply_stimulus(1'b1, 1'b1);
    for (int i = 0; i < 100 && hs_count - mark < 4; i++) apply_stimulus(1'b1, 1'b0);
    host_addr = 5'd5;
    host_pend = 1'b1;
    run_to_done(300);
    check_output("t3_acks", ack_count - mark_ack, 1);
    check_output("t3_ack_position", ack_hs - mark, 5);
    check_output("t3_bytes", hs_count - mark, 19);

    $display("[TB] frame and host read together");
    push_frame();
    inflight = 1'b1;
    host_addr = 5'd9;
    host_pend = 1'b1;
    mark = hs_count;
    mark_ack = ack_count;
    apply_stimulus(1'b1, 1'b1);
    for (int i = 0; i < 50 && ack_count == mark_ack; i++) apply_stimulus(1'b1, 1'b0);
    check_output("t4_ack", ack_count - mark_ack, 1);
    check_output("t4_ack_first", ack_hs - mark, 0);
    check_output("t4_no_ovr", ovr_cnt, 0);
    check_output("t4_busy_pending", busy, 1);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 100 && hs_count - mark < 3 * (p + 1); i++) apply_stimulus(1'b1, 1'b0);
      apply_stimulus(1'b1, 1'b1);
    end
    run_to_done(300);
    check_output("t4_ovr3", ovr_cnt, 3);

    $display("[TB] overrun saturation");
    push_frame();
    inflight = 1'b1;
    mark = hs_count;
    apply_stimulus(1'b0, 1'b1);
    for (int i = 0; i < 251; i++) apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0);
    check_output("t5_ovr254", ovr_cnt, 254);
    for (int i = 0; i < 9; i++) apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0);
    check_output("t5_ovr_sat", ovr_cnt, 255);
    check_output("t5_hdr_held", tx_data, HDRB);
    run_to_done(300);
    check_output("t5_bytes", hs_count - mark, 19);

    $display("[TB] reset during read wait");
    push_frame();
    inflight = 1'b1;
    mark = hs_count;
    apply_stimulus(1'b1, 1'b1);
    for (int i = 0; i < 100 && hs_count - mark < 5; i++) apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    check_output("t6_addr_in_wait", addr, 5'd4);
    rst = 1'b0;
    exp_q.delete();
    inflight = 1'b0;
    apply_stimulus(1'b1, 1'b0);
    check_output("t6_tx_val", tx_val, 0);
    check_output("t6_addr", addr, PARK);
    check_output("t6_ovr", ovr_cnt, 0);
    check_output("t6_busy", busy, 0);
    rst = 1'b1;
    push_frame();
    inflight = 1'b1;
    mark = hs_count;
    apply_stimulus(1'b1, 1'b1);
    run_to_done(300);
    check_output("t6_restart_bytes", hs_count - mark, 19);

    $display("[TB] random traffic");
    started = 0;
    exp_ovr = 0;
    mark_done = done_count;
    for (int cyc = 0; cyc < 8000 && (started < 6 || inflight || host_pend); cyc++) begin
      fr = 1'b0;
      if (started < 6 && !inflight && $urandom_range(0, 7) == 0) begin
        push_frame();
        inflight = 1'b1;
        started++;
        fr = 1'b1;
      end else if (inflight && exp_q.size() >= 2 && $urandom_range(0, 39) == 0) begin
        fr = 1'b1;
        exp_ovr++;
      end
      if (!host_pend && (started < 6 || inflight) && $urandom_range(0, 15) == 0) begin
        host_pend = 1'b1;
        host_addr = 5'($urandom_range(0, 31));
      end
      apply_stimulus($urandom_range(0, 3) != 0, fr);
    end
    check_output("rnd_frames", done_count - mark_done, 6);
    check_output("rnd_ovr", ovr_cnt, exp_ovr);
    check_output("rnd_host_drained", host_pend, 0);
    check_output("rnd_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/answer_poll_sched.md
Name: answer_poll_sched

Overview:
- Sequences reads of the addressed telemetry answer table (5-bit addr in, registered 8-bit data out) and streams one full frame of answer bytes to the UART transmitter.
- Shares the table's single address port between two requesters: the periodic frame trigger and a host single-address read.
- Sits between the answer table, the UART TX byte interface and the host/bus logic.

Parameters:
- FIRST_ADDR, 0, first table address of a frame sweep.
- LAST_ADDR, 17, last table address of a frame sweep (inclusive; must be ≥ FIRST_ADDR).
- PARK_ADDR, 1, address driven while idle; must be side-effect-free (not 0 or 17).
- READ_LAT, 2, cycles from addr change to valid table data (1..3).
- HEADER, 8'hA5, sync byte sent before each frame's data bytes.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- frame_req  in  1  one-cycle pulse requesting a frame sweep.
- rd_req  in  1  host single-read request, held until rd_ack.
- rd_addr  in  5  host read address, stable while rd_req is high.
- rd_ack  out  1  one-cycle pulse; rd_data is valid in this cycle.
- rd_data  out  8  host read result.
- addr  out  5  registered address to the answer table.
- data  in  8  answer table read data.
- tx_data  out  8  byte to the UART transmitter.
- tx_val  out  1  tx_data valid.
- tx_rdy  in  1  transmitter accepts the byte when tx_val & tx_rdy.
- busy  out  1  high in any state other than IDLE, or while a frame is pending.
- frame_done  out  1  one-cycle pulse after the last frame byte handshakes.
- ovr_cnt  out  8  count of dropped frame_req pulses; saturates at 255.

Behaviour:
- Reset (rst=0 at a clk edge), also mid-operation:
  - state goes to IDLE; addr=PARK_ADDR; tx_val=0; tx_data=0; rd_ack=0; rd_data=0; frame_done=0; ovr_cnt=0.
  - Pending flag, sweep index and wait counter are cleared. Any partially sent frame is abandoned.
- States: IDLE, HDR, SETUP, WAIT, SEND, HSETUP, HWAIT.
- IDLE:
  - rd_req has priority: go to HSETUP.
  - Otherwise, if the pending flag is set or frame_req=1: clear pending, set sweep index to FIRST_ADDR, go to HDR.
- HDR: tx_val=1, tx_data=HEADER. Hold until tx_rdy, then go to SETUP.
- SETUP: addr <= index; wait counter <= READ_LAT-1; go to WAIT.
- WAIT:
  - Decrement the wait counter.
  - At 0: capture data into tx_data, assert tx_val, go to SEND.
  - Capture happens exactly READ_LAT cycles after the addr register update.
- SEND:
  - tx_val and tx_data are held stable until tx_rdy.
  - On handshake, tx_val drops next cycle. Then:
    - if index==LAST_ADDR: pulse frame_done, addr <= PARK_ADDR, go to IDLE.
    - else if rd_req: index+1 is stored, go to HSETUP (host read interleaved between frame bytes).
    - else: index+1, go to SETUP.
- HSETUP: addr <= rd_addr; go to HWAIT with wait counter as in SETUP.
- HWAIT:
  - At 0: rd_data <= data; pulse rd_ack.
  - Return to SETUP if a frame is in progress, else to IDLE with addr <= PARK_ADDR.
- Host reads never touch tx_*. At most one host read is inserted between consecutive frame bytes, so a frame cannot be starved.
- frame_req handling:
  - Arriving during HSETUP/HWAIT with no frame in progress, or in IDLE while rd_req wins: sets the pending flag.
  - Arriving while a frame is in progress, or while pending is already set: ovr_cnt +1, saturating at 255.
- addr changes only in SETUP, HSETUP, or on return to IDLE. No other glitches of addr, so each table address side effect happens once per visit.
- Frame length is LAST_ADDR-FIRST_ADDR+2 bytes; the default is 19.
- Minimum cycles per data byte with tx_rdy=1: 1 (SETUP) + READ_LAT (WAIT) + 1 (SEND).

Test Plan:
- Table model returns addr*10 at READ_LAT=2; tx_rdy=1; pulse frame_req -> tx bytes A5,0(cnt),10,20,…,150, then bytes 16 and 17 from the model. frame_done pulses once, 19 bytes total, addr back to 1.
- tx_rdy low for 5 cycles at byte 3 -> tx_val and tx_data (20) stay stable for the whole stall; no byte is lost or duplicated; addr does not change.
- rd_req with rd_addr=5 asserted mid-frame -> rd_ack with rd_data=50 inserted after the current byte handshake; the frame then continues with the next address in order.
- frame_req and rd_req(addr 9) in the same IDLE cycle -> rd_ack with 90 first, then the frame starts with no ovr_cnt increment; 3 extra frame_req pulses during the frame -> ovr_cnt=3.
- 260 frame_req pulses during busy -> ovr_cnt saturates at 255.
- rst=0 in WAIT mid-frame -> next cycle: IDLE, tx_val=0, addr=1, ovr_cnt=0. A new frame_req restarts from HEADER.
